// File: rtl/mostra_sequencia_pkg.sv
// Shared constants for the sequence display blocks: FSM state encodings,
// default dwell times and small elaboration-time helpers.
package mostra_sequencia_pkg;

  // FSM states; the numeric encoding is what db_estado shows.
  typedef enum logic [2:0] {
    INICIAL = 3'd0,
    CARREGA = 3'd1,
    LE      = 3'd2,
    MOSTRA  = 3'd3,
    APAGA   = 3'd4,
    FIM     = 3'd5
  } estado_t;

  // Default dwell times in clock cycles.
  localparam int T_ON_PADRAO  = 1000;
  localparam int T_OFF_PADRAO = 500;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Counter width for a modulo-m counter; never narrower than one bit.
  function automatic int largura(input int m);
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/mostra_sequencia_contador_m.sv
// Modulo-M up counter used as the dwell timer. zera has priority over conta.
module mostra_sequencia_contador_m
  import mostra_sequencia_pkg::*;
#(
  parameter  int M = 16,
  localparam int W = largura(M)
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         zera,
  input  logic         conta,
  output logic [W-1:0] q
);

  localparam logic [W-1:0] ULTIMO = W'(M - 1);

  logic [W-1:0] r_q;

  // Count state: synchronous clear, otherwise wrap at M-1 when enabled.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_q <= '0;
    end else if (zera) begin
      r_q <= '0;
    end else if (conta) begin
      r_q <= (r_q == ULTIMO) ? '0 : r_q + 1'b1;
    end
  end

  assign q = r_q;

endmodule

// File: rtl/mostra_sequencia.sv
// Shows ROM items 0..limite on leds, each lit for T_ON cycles followed by
// T_OFF blank cycles, then pulses pronto. The ROM is external and
// synchronous: dado reflects endereco one edge after it is captured.
module mostra_sequencia
  import mostra_sequencia_pkg::*;
#(
  parameter int T_ON  = T_ON_PADRAO,
  parameter int T_OFF = T_OFF_PADRAO
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       parar,
  input  logic [3:0] limite,
  input  logic [3:0] dado,
  output logic [3:0] endereco,
  output logic [3:0] leds,
  output logic       ocupado,
  output logic       pronto,
  output logic [3:0] db_estado
);

  localparam int M = max_int(T_ON, T_OFF);
  localparam int W = largura(M);
  localparam logic [W-1:0] ULT_ON  = W'(T_ON - 1);
  localparam logic [W-1:0] ULT_OFF = W'(T_OFF - 1);

  estado_t    r_estado, w_prox_estado;
  logic [3:0] r_endereco, w_prox_endereco;
  logic [3:0] r_leds, w_prox_leds;
  logic [3:0] r_limite, w_prox_limite;
  logic [W-1:0] w_timer;
  logic       w_conta, w_zera;

  // Timer runs only while dwelling in MOSTRA/APAGA; any state change
  // (including entry to MOSTRA or APAGA) restarts it from zero.
  assign w_conta = (r_estado == MOSTRA) || (r_estado == APAGA);
  assign w_zera  = (w_prox_estado != r_estado) || !w_conta;

  mostra_sequencia_contador_m #(.M(M)) u_timer (
    .clock (clock),
    .reset (reset),
    .zera  (w_zera),
    .conta (w_conta),
    .q     (w_timer)
  );

  // State and registered datapath.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_estado   <= INICIAL;
      r_endereco <= '0;
      r_leds     <= '0;
      r_limite   <= '0;
    end else begin
      r_estado   <= w_prox_estado;
      r_endereco <= w_prox_endereco;
      r_leds     <= w_prox_leds;
      r_limite   <= w_prox_limite;
    end
  end

  // Next-state and datapath updates; parar overrides everything outside INICIAL.
  always_comb begin
    w_prox_estado   = r_estado;
    w_prox_endereco = r_endereco;
    w_prox_leds     = r_leds;
    w_prox_limite   = r_limite;
    if (r_estado != INICIAL && parar) begin
      w_prox_estado   = INICIAL;
      w_prox_endereco = '0;
      w_prox_leds     = '0;
    end else begin
      case (r_estado)
        INICIAL: begin
          if (iniciar) begin
            w_prox_estado   = CARREGA;
            w_prox_endereco = '0;
            w_prox_limite   = limite;
          end
        end
        CARREGA: w_prox_estado = LE;
        LE: begin
          w_prox_estado = MOSTRA;
          w_prox_leds   = dado;
        end
        MOSTRA: begin
          if (w_timer == ULT_ON) begin
            w_prox_estado = APAGA;
            w_prox_leds   = '0;
          end
        end
        APAGA: begin
          if (w_timer == ULT_OFF) begin
            if (r_endereco == r_limite) begin
              w_prox_estado = FIM;
            end else begin
              w_prox_estado   = CARREGA;
              w_prox_endereco = r_endereco + 4'd1;
            end
          end
        end
        FIM:     w_prox_estado = INICIAL;
        default: w_prox_estado = INICIAL;
      endcase
    end
  end

  assign endereco  = r_endereco;
  assign leds      = r_leds;
  assign ocupado   = (r_estado != INICIAL);
  assign pronto    = (r_estado == FIM);
  assign db_estado = {1'b0, r_estado};

endmodule

// File: tb/tb_mostra_sequencia.sv
// Directed bench for mostra_sequencia with a 16x4 synchronous ROM model.
// Expected item values are queued at each start and popped as items light up.
module tb_mostra_sequencia;

  localparam int T_ON  = 4;
  localparam int T_OFF = 2;
  localparam int PER   = 2 + T_ON + T_OFF;

  // ---------------- clock / reset / DUT ----------------
  logic       clock   = 1'b0;
  logic       reset   = 1'b0;
  logic       iniciar = 1'b0;
  logic       parar   = 1'b0;
  logic [3:0] limite  = 4'd0;
  logic [3:0] dado    = 4'd0;
  logic [3:0] endereco, leds, db_estado;
  logic       ocupado, pronto;

  always #5 clock = ~clock;

  mostra_sequencia #(.T_ON(T_ON), .T_OFF(T_OFF)) dut (
    .clock     (clock),
    .reset     (reset),
    .iniciar   (iniciar),
    .parar     (parar),
    .limite    (limite),
    .dado      (dado),
    .endereco  (endereco),
    .leds      (leds),
    .ocupado   (ocupado),
    .pronto    (pronto),
    .db_estado (db_estado)
  );

  // ROM contents 0x1,0x2,0x4,0x8 repeating; registered read.
  logic [3:0] rom [16];
  initial for (int i = 0; i < 16; i++) rom[i] = 4'(1 << (i % 4));
  always @(posedge clock) dado <= rom[endereco];

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;
  logic [3:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Monitor: item values, lit length and blank gap between items of a run.
  int         scen_id    = 0;
  int         last_scen  = 0;
  bit         full_runs  = 1'b1;
  bit         seen_item  = 1'b0;
  logic [3:0] prev_leds  = 4'd0;
  int         run_len    = 0;
  int         gap_len    = 0;
  int         pronto_cnt = 0;

  always @(negedge clock) begin
    if (scen_id != last_scen) begin
      seen_item = 1'b0;
      last_scen = scen_id;
    end
    if (leds !== prev_leds) begin
      if (leds != 4'd0) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_item", {28'd0, leds}, 32'd0);
        end else begin
          chk("item_value", {28'd0, leds}, {28'd0, exp_q.pop_front()});
        end
        // Blank between items: APAGA (T_OFF) plus CARREGA and LE.
        if (full_runs && seen_item && prev_leds == 4'd0)
          chk("blank_gap", gap_len, 2 + T_OFF);
        seen_item = 1'b1;
        run_len   = 1;
      end else begin
        if (full_runs) chk("lit_len", run_len, T_ON);
        gap_len = 1;
      end
    end else if (leds != 4'd0) begin
      run_len++;
    end else begin
      gap_len++;
    end
    prev_leds = leds;
    if (pronto === 1'b1) pronto_cnt++;
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Pulses iniciar across one edge (edge k) and returns the cycle stamp of k.
  task automatic start(input logic [3:0] lim, output int k);
    limite  = lim;
    iniciar = 1'b1;
    step();
    k       = cyc;
    iniciar = 1'b0;
  endtask

  task automatic wait_pronto(input int budget, input int k, output int n, output int max_end);
    n       = -1;
    max_end = endereco;
    for (int i = 0; i < budget; i++) begin
      step();
      if (int'(endereco) > max_end) max_end = endereco;
      if (pronto === 1'b1) begin
        n = cyc - k;
        break;
      end
    end
  endtask

  task automatic wait_state(input logic [3:0] s, input logic [3:0] a, input int budget, input string tag);
    bit found = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (db_estado === s && endereco === a) begin
        found = 1'b1;
        break;
      end
      step();
    end
    if (!found && db_estado === s && endereco === a) found = 1'b1;
    chk(tag, {31'd0, found}, 32'd1);
  endtask

  task automatic push_items(input int count);
    for (int i = 0; i < count; i++) exp_q.push_back(rom[i]);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int k, n, max_end, p0;

    // Reset state
    repeat (3) @(posedge clock);
    #1;
    chk("rst_leds",     leds,      0);
    chk("rst_endereco", endereco,  0);
    chk("rst_ocupado",  ocupado,   0);
    chk("rst_pronto",   pronto,    0);
    chk("rst_estado",   db_estado, 0);
    reset = 1'b1;
    repeat (2) step();
    chk("idle_estado", db_estado, 0);

    // limite=3: items 1,2,4,8, pronto at 4*PER
    scen_id = 1;
    push_items(4);
    start(4'd3, k);
    chk("s1_estado_carrega", db_estado, 1);
    chk("s1_ocupado",        ocupado,   1);
    chk("s1_endereco0",      endereco,  0);
    wait_pronto(300, k, n, max_end);
    chk("s1_pronto_cycle", n, 4 * PER);
    chk("s1_max_end",      max_end, 3);
    step();
    chk("s1_pronto_width", pronto,    0);
    chk("s1_back_idle",    db_estado, 0);
    chk("s1_queue_empty",  exp_q.size(), 0);

    // limite=0 with parar also high in INICIAL: iniciar wins, one item
    scen_id = 2;
    push_items(1);
    parar = 1'b1;
    start(4'd0, k);
    parar = 1'b0;
    chk("s2_iniciar_wins", db_estado, 1);
    wait_pronto(100, k, n, max_end);
    chk("s2_pronto_cycle", n, PER);
    chk("s2_max_end",      max_end, 0);
    step();
    chk("s2_queue_empty",  exp_q.size(), 0);

    // limite=15: 16 items, endereco stops at 15
    scen_id = 3;
    push_items(16);
    start(4'd15, k);
    wait_pronto(500, k, n, max_end);
    chk("s3_pronto_cycle",   n, 16 * PER);
    chk("s3_max_end",        max_end, 15);
    chk("s3_end_at_pronto",  endereco, 15);
    step();
    chk("s3_queue_empty",    exp_q.size(), 0);

    // parar during MOSTRA of item 2
    scen_id   = 4;
    full_runs = 1'b0;
    p0        = pronto_cnt;
    push_items(2);
    start(4'd3, k);
    wait_state(4'd3, 4'd1, 50, "s4_reach_mostra2");
    step();
    parar = 1'b1;
    step();
    parar = 1'b0;
    chk("s4_leds",     leds,      0);
    chk("s4_estado",   db_estado, 0);
    chk("s4_endereco", endereco,  0);
    chk("s4_ocupado",  ocupado,   0);
    repeat (40) step();
    chk("s4_no_pronto",    pronto_cnt - p0, 0);
    chk("s4_still_idle",   db_estado, 0);
    chk("s4_queue_empty",  exp_q.size(), 0);
    full_runs = 1'b1;

    // reset during APAGA: outputs clear without a clock edge
    scen_id = 5;
    p0      = pronto_cnt;
    push_items(1);
    start(4'd3, k);
    wait_state(4'd4, 4'd0, 30, "s5_reach_apaga");
    #2 reset = 1'b0;
    #1;
    chk("s5_leds",     leds,      0);
    chk("s5_endereco", endereco,  0);
    chk("s5_ocupado",  ocupado,   0);
    chk("s5_pronto",   pronto,    0);
    chk("s5_estado",   db_estado, 0);
    repeat (2) step();
    reset = 1'b1;
    repeat (20) step();
    chk("s5_idle_estado",  db_estado, 0);
    chk("s5_idle_ocupado", ocupado,   0);
    chk("s5_idle_leds",    leds,      0);
    chk("s5_no_pronto",    pronto_cnt - p0, 0);
    chk("s5_queue_empty",  exp_q.size(), 0);

    // iniciar re-pulsed and limite changed mid-sequence: original limite=1 kept
    scen_id = 6;
    push_items(2);
    start(4'd1, k);
    wait_state(4'd3, 4'd0, 20, "s6_reach_mostra1");
    iniciar = 1'b1;
    limite  = 4'd3;
    step();
    iniciar = 1'b0;
    chk("s6_no_restart", db_estado, 3);
    wait_pronto(200, k, n, max_end);
    chk("s6_pronto_cycle", n, 2 * PER);
    chk("s6_max_end",      max_end, 1);
    repeat (3) step();
    chk("s6_queue_empty",  exp_q.size(), 0);
    chk("s6_idle",         db_estado, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mostra_sequencia.md
MOSTRA_SEQUENCIA -- requirements
Module: mostra_sequencia

Interface
REQ-001 Parameter T_ON, default 1000, number of clock cycles each sequence item is lit on leds.
REQ-002 Parameter T_OFF, default 500, number of blank clock cycles after each lit item.
REQ-003 clock  in  1  single system clock; all state changes on its rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset; clears all state while low.
REQ-005 iniciar  in  1  start request, sampled only in INICIAL.
REQ-006 parar  in  1  synchronous abort, honoured in every state except INICIAL.
REQ-007 limite  in  4  address of the last item to show; captured at start.
REQ-008 dado  in  4  data from the external sync_rom_16x4, valid one edge after endereco changes.
REQ-009 endereco  out  4  ROM address, registered.
REQ-010 leds  out  4  displayed item, registered; 0 means blank.
REQ-011 ocupado  out  1  high in every state except INICIAL.
REQ-012 pronto  out  1  one-cycle pulse when the full sequence has been shown.
REQ-013 db_estado  out  4  current state encoding, for debug displays.

Function
REQ-014 FSM states SHALL be INICIAL, CARREGA, LE, MOSTRA, APAGA and FIM, encoded 0 to 5.
REQ-015 INICIAL with iniciar=1 at edge k SHALL go to CARREGA, set endereco=0 and latch limite.
REQ-016 CARREGA SHALL last exactly 1 cycle, then go to LE; the ROM captures endereco at that edge.
REQ-017 At the edge leaving LE, leds SHALL load dado and the FSM SHALL enter MOSTRA; the first item is therefore visible from edge k+2.
REQ-018 MOSTRA SHALL last exactly T_ON cycles, holding leds constant, then go to APAGA with leds=0.
REQ-019 APAGA SHALL last exactly T_OFF cycles with leds=0.
REQ-020 At the end of APAGA, if endereco equals the latched limite, the FSM SHALL go to FIM; otherwise endereco SHALL increment and the FSM SHALL go to CARREGA.
REQ-021 FIM SHALL last 1 cycle with pronto=1, then go to INICIAL.
REQ-022 One item period SHALL be 2+T_ON+T_OFF cycles; N=limite+1 items; pronto SHALL assert N*(2+T_ON+T_OFF) cycles after edge k.
REQ-023 limite=0 SHALL show exactly one item; limite=15 SHALL show 16 items with no wrap and no endereco overflow.
REQ-024 iniciar SHALL be ignored while ocupado=1; changes to limite after start SHALL have no effect.
REQ-025 parar=1 in any non-INICIAL state SHALL force INICIAL at the next edge with leds=0 and endereco=0, and SHALL NOT pulse pronto.
REQ-026 If parar and iniciar are both 1 in INICIAL, iniciar SHALL win.
REQ-027 The timer SHALL be cleared on entry to MOSTRA and on entry to APAGA.

Reset
REQ-028 While reset=0, the block SHALL hold: state=INICIAL, endereco=0, leds=0, pronto=0, ocupado=0, timer=0, latched limite=0.
REQ-029 Reset asserted mid-sequence SHALL abort immediately without a pronto pulse; after release, the block SHALL wait for a new iniciar.

Structure
REQ-030 State encodings and the default T_ON/T_OFF values SHALL live in the shared constants package/include used by the game blocks.
REQ-031 The dwell timer SHALL be one instance of the existing contador_m, with M = max(T_ON,T_OFF), compared against T_ON or T_OFF by state.
REQ-032 The ROM SHALL remain external; this block only drives endereco and reads dado.

Verification (T_ON=4, T_OFF=2, ROM holds 0x1,0x2,0x4,0x8,...)
REQ-033 Bench SHALL cover: limite=3, iniciar pulse -> leds shows 1,2,4,8 for 4 cycles each, with 2 blank cycles between; pronto is high for 1 cycle at cycle 32 after start.
REQ-034 Bench SHALL cover: limite=0 -> a single item 0x1 is shown; pronto at cycle 8; endereco stays at 0.
REQ-035 Bench SHALL cover: limite=15 -> 16 items are shown, endereco reaches 15 and does not wrap; pronto at cycle 128.
REQ-036 Bench SHALL cover: parar=1 during the MOSTRA of item 2 -> leds=0 and INICIAL at the next edge; pronto never asserts.
REQ-037 Bench SHALL cover: reset=0 during APAGA -> all outputs are 0 immediately, without waiting for a clock edge; after release with no iniciar, the block stays idle.
REQ-038 Bench SHALL cover: iniciar re-pulsed and limite changed mid-sequence -> no restart; the original limite is honoured.
